// File: rtl/regfile_pkg.sv
// regfile_pkg: shared op codes and FSM states for the register bank
package regfile_pkg;

   typedef enum logic [2:0] {
      OP_NOP       = 3'b000,
      OP_CLEAR     = 3'b001,
      OP_MOV_RN_R0 = 3'b010,
      OP_MOV_R0_RN = 3'b011,
      OP_LOAD_OR2  = 3'b100,
      OP_LOAD_ALU  = 3'b101,
      OP_READ      = 3'b110,
      OP_SWAP      = 3'b111
   } regfile_op_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_CLEARING = 1'b1
   } regfile_state_t;

endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: handshaken register bank with R0 accumulator, sequenced clear, swap and registered reads
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_op_valid,
   output logic              o_op_ready,
   input  logic [2:0]        i_op,
   input  logic [ADDR_W-1:0] i_sel,
   input  logic [WIDTH-1:0]  i_or2_in,
   input  logic [WIDTH-1:0]  i_alu_in,
   output logic [WIDTH-1:0]  o_dataout_a,
   output logic [WIDTH-1:0]  o_dataout_b,
   output logic              o_rd_valid
);

   regfile_state_t    r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [WIDTH-1:0]  r_regs [DEPTH];

   regfile_op_t       w_op;
   logic              w_accept;
   logic              w_rn_we;
   logic              w_r0_we;
   logic              w_read;
   logic              w_clearing;
   logic              w_last;
   logic [WIDTH-1:0]  w_rn_d;
   logic [WIDTH-1:0]  w_rn_q;

   assign o_op_ready = (r_state == ST_IDLE);

   // decode the accepted op into R0/RN write enables and RN write data
   always_comb begin
      w_op       = regfile_op_t'(i_op);
      w_accept   = i_op_valid && o_op_ready;
      w_clearing = (r_state == ST_CLEARING);
      w_last     = (r_cnt == ADDR_W'(DEPTH - 1));
      w_rn_q     = r_regs[i_sel];
      w_read     = w_accept && (w_op == OP_READ);
      w_rn_we    = w_accept && (w_op inside {OP_MOV_RN_R0, OP_LOAD_OR2, OP_LOAD_ALU, OP_SWAP});
      w_r0_we    = w_accept && (w_op == OP_MOV_R0_RN || w_op == OP_SWAP);
      w_rn_d     = (w_op == OP_LOAD_OR2) ? i_or2_in :
                   (w_op == OP_LOAD_ALU) ? i_alu_in : r_regs[0];
   end

   // register array: clear sweep first, then RN write (covers sel=0 loads), then R0 write
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_clearing && r_cnt == ADDR_W'(k)) r_regs[k] <= '0;
            else if (w_rn_we && i_sel == ADDR_W'(k)) r_regs[k] <= w_rn_d;
            else if (w_r0_we && k == 0) r_regs[k] <= w_rn_q;
         end
      end
   end

   // two-state sequencer: one register zeroed per cycle while clearing
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (w_clearing) begin
         r_cnt   <= r_cnt + 1'b1;
         r_state <= w_last ? ST_IDLE : ST_CLEARING;
      end else if (w_accept && w_op == OP_CLEAR) begin
         r_cnt   <= '0;
         r_state <= ST_CLEARING;
      end
   end

   // registered read port; values hold until the next READ
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_dataout_a <= '0;
         o_dataout_b <= '0;
         o_rd_valid  <= 1'b0;
      end else begin
         o_rd_valid <= w_read;
         if (w_read) begin
            o_dataout_a <= r_regs[0];
            o_dataout_b <= w_rn_q;
         end
      end
   end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised general-purpose register bank for the RNBIP-2 datapath: DEPTH registers of WIDTH bits, R0 as accumulator and RN selected by `sel`. It replaces the fixed 8-entry register file with a clocked, handshaken block. It adds a multi-cycle sequenced clear, an atomic R0/RN swap and registered read ports with a valid strobe. It sits between the operand register (OR2), the ALU result bus and the ALU operand inputs.

## Interface
- `WIDTH`, 8: data width of each register and of all data ports.
- `DEPTH`, 8: number of registers; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): derived; width of `sel`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid` in 1: an operation is presented.
- `op_ready` out 1: the block can accept an operation this cycle.
- `op` in 3: operation code, see Operation.
- `sel` in ADDR_W: RN index.
- `or2_in` in WIDTH: operand-register data.
- `alu_in` in WIDTH: ALU result data.
- `dataout_a` out WIDTH: registered R0 read value.
- `dataout_b` out WIDTH: registered RN read value.
- `rd_valid` out 1: one-cycle strobe; the dataout pair was updated by READ.

## Operation
- Accept on a rising edge with `op_valid && op_ready`. Exactly one operation per accepted cycle. When nothing is accepted, state and registers hold.
- Op codes:
  - 000 NOP: no effect.
  - 001 CLEAR: sequenced clear of all registers.
  - 010 MOV_RN_R0: RN ← R0.
  - 011 MOV_R0_RN: R0 ← RN.
  - 100 LOAD_OR2: RN ← `or2_in`.
  - 101 LOAD_ALU: RN ← `alu_in`.
  - 110 READ: `dataout_a` ← R0, `dataout_b` ← RN, `rd_valid` ← 1.
  - 111 SWAP: R0 ↔ RN, atomic.
- When `sel` = 0, MOV_RN_R0, MOV_R0_RN and SWAP leave contents unchanged. LOAD_* with `sel` = 0 writes R0.
- Two-state FSM, IDLE and CLEARING:
  - IDLE: `op_ready` = 1. An accepted CLEAR moves to CLEARING with clear counter = 0.
  - CLEARING: `op_ready` = 0. Each cycle writes 0 to register[counter], then increments the counter. When counter = DEPTH-1 that register is zeroed and the FSM returns to IDLE.
  - CLEAR therefore occupies DEPTH cycles, and `op_ready` rises on the cycle after the last register is zeroed.
- `dataout_a`/`dataout_b` hold their last READ values. They change only on READ or reset.
- Width rules: all data paths are exactly WIDTH bits, with no extension or truncation. The clear counter is ADDR_W bits and wraps naturally at DEPTH-1.

## Timing
- Reset (async assert, applies immediately):
  - all registers = 0
  - `dataout_a` = `dataout_b` = 0, `rd_valid` = 0
  - FSM = IDLE, counter = 0, `op_ready` = 1 while and after reset
- Reset during CLEARING aborts the sequence. The block is in IDLE with all registers zero on release.
- Write ops: new contents are visible to the next accepted operation, i.e. 1-cycle latency.
- READ latency: data and `rd_valid` appear one cycle after acceptance. `rd_valid` is high for exactly one cycle per READ; back-to-back READs keep it high.
- READ in the cycle right after a write returns the written value. There is no stale-read window.
- `op_valid` while `op_ready` = 0 is ignored. The requester must hold `op_valid`/`op`/`sel` until it sees acceptance.
- `or2_in`/`alu_in` are sampled only on the accepting edge.

## Structure
- Shared package `regfile_pkg`:
  - op-code localparams or enum `regfile_op_t` with the eight codes above
  - FSM state enum `regfile_state_t` (IDLE, CLEARING)
- Single module. The clear counter and FSM are small enough to stay inline; no sub-module.

## Test plan
- Reset then READ `sel`=3 → one cycle later `dataout_a`=0x00, `dataout_b`=0x00, `rd_valid`=1 for one cycle.
- LOAD_OR2 `sel`=2 `or2_in`=0xA5, then LOAD_ALU `sel`=0 `alu_in`=0x3C, then SWAP `sel`=2, then READ `sel`=2 → `dataout_a`=0xA5, `dataout_b`=0x3C.
- MOV_RN_R0 `sel`=5 after R0=0x7E, then MOV_R0_RN `sel`=2 with R2=0x11, then READ `sel`=5 → A=0x11, B=0x7E. Same sequence with `sel`=0 → contents unchanged.
- Fill all registers with nonzero values, then CLEAR:
  - `op_ready` low for exactly DEPTH cycles (8 by default)
  - a READ held during that time is accepted only after `op_ready` rises and returns 0/0
- Assert `rst` at clear cycle 3 with R5=0xFF pending → immediate IDLE, `op_ready`=1, READ `sel`=5 returns 0x00.
- Rerun the first two scenarios with WIDTH=16, DEPTH=16: LOAD_OR2 `sel`=15 with 0xBEEF, then READ `sel`=15 → B=0xBEEF.
